// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Brief    : Shared FSM encodings, register bit positions and default
//            addresses for the memory-mapped UART transmitter.
// Revision : 1.0
// ============================================================================
package uart_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Named view of the state register, handy when probing waveforms.
    typedef enum logic [2:0] {
        E_IDLE   = ST_IDLE,
        E_START  = ST_START,
        E_DATA   = ST_DATA,
        E_PARITY = ST_PARITY,
        E_STOP   = ST_STOP
    } uart_tx_state_e;

    localparam int CB_READY = 0;
    localparam int CB_IDLE  = 1;
    localparam int CB_OVR   = 2;
    localparam int CB_PEN   = 4;
    localparam int CB_PODD  = 5;
    localparam int CB_IE    = 8;

    localparam logic [15:0] DEF_DADDR = 16'hFFD0;
    localparam logic [15:0] DEF_CADDR = 16'hFFD4;

    function automatic logic calc_parity(input logic [7:0] i_data, input logic i_odd);
        return (^i_data) ^ i_odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_dev_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_dev_if
// Brief    : Processor data-bus request signals seen by the UART transmitter.
// Revision : 1.0
// ============================================================================
interface uart_tx_dev_if #(
    parameter int ABITS = 16,
    parameter int DBITS = 16
);
    logic [ABITS-1:0] ABUS;
    logic             RE;
    logic [DBITS-1:0] WBUS;
    logic             WE;

    modport master (output ABUS, RE, WBUS, WE);
    modport slave  (input  ABUS, RE, WBUS, WE);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Small synchronous FIFO with occupancy count; DEPTH power of 2.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic      [CW-1:0]    o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_dev.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_dev
// Brief    : Memory-mapped 8N1 serial transmitter with FIFO and interrupt.
//            Optional parity bit enabled by defining UART_TX_PARITY_EN.
// Revision : 1.0
// ============================================================================
module uart_tx_dev
    import uart_tx_pkg::*;
#(
    parameter int               ABITS  = 16,
    parameter int               DBITS  = 16,
    parameter logic [ABITS-1:0] DADDR  = ABITS'(DEF_DADDR),
    parameter logic [ABITS-1:0] CADDR  = ABITS'(DEF_CADDR),
    parameter int               DIVN   = 434,
    parameter int               DIVB   = 9,
    parameter int               FDEPTH = 4
) (
    input  wire logic       CLK,
    input  wire logic       RSTN,
    uart_tx_dev_if.slave    i_bus,
    inout  wire [DBITS-1:0] RBUS,
    output logic            INTR,
    output logic            TXD
);
    localparam int CW = $clog2(FDEPTH + 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nx;
    logic [DIVB-1:0]  r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_txd;
    logic             r_intr;
    logic             r_ie;
    logic             r_ovr;

    logic             w_wr_data;
    logic             w_wr_ctrl;
    logic             w_rd_en;
    logic [DBITS-1:0] w_rd_val;
    logic [DBITS-1:0] w_status;
    logic             w_bit_end;
    logic             w_pop;
    logic             w_txd;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic [7:0]       w_fifo_rdata;
    logic             w_unused_wbus;

`ifdef UART_TX_PARITY_EN
    logic             r_pen;
    logic             r_podd;
    logic             r_fpen;
    logic             r_par;
`endif

    assign w_wr_data = i_bus.WE & (i_bus.ABUS == DADDR);
    assign w_wr_ctrl = i_bus.WE & (i_bus.ABUS == CADDR);
    assign w_unused_wbus = ^i_bus.WBUS[DBITS-1:9];

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FDEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RSTN),
        .i_push  (w_wr_data),
        .i_wdata (i_bus.WBUS[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_bit_end = (r_cnt == DIVB'(DIVN - 1));
    // A frame starts from IDLE, or straight out of a finishing stop bit.
    assign w_pop = ~w_empty & ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_bit_end));

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_state_nx = ST_START;
            end
            ST_START: begin
                if (w_bit_end) w_state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end && (r_bit == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nx = r_fpen ? ST_PARITY : ST_STOP;
`else
                    w_state_nx = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) w_state_nx = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_bit_end) w_state_nx = w_empty ? ST_IDLE : ST_START;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        w_txd = 1'b1;
        case (r_state)
            ST_START: w_txd = 1'b0;
            ST_DATA:  w_txd = r_shift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_txd = r_par;
`endif
            default:  w_txd = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_txd   <= w_txd;
            if (w_pop) begin
                r_shift <= w_fifo_rdata;
                r_cnt   <= '0;
                r_bit   <= '0;
            end else if (r_state != ST_IDLE) begin
                if (w_bit_end) begin
                    r_cnt <= '0;
                    if (r_state == ST_DATA) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                    end
                end else begin
                    r_cnt <= r_cnt + DIVB'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_ie   <= 1'b0;
            r_ovr  <= 1'b0;
            r_intr <= 1'b0;
        end else begin
            r_intr <= r_ie & ~w_full;
            if (w_wr_data && w_full) begin
                r_ovr <= 1'b1;
            end
            if (w_wr_ctrl) begin
                r_ie <= i_bus.WBUS[CB_IE];
                if (!i_bus.WBUS[CB_OVR]) r_ovr <= 1'b0;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity mode is captured per frame so a mid-frame control write cannot tear it.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_pen  <= 1'b0;
            r_podd <= 1'b0;
            r_fpen <= 1'b0;
            r_par  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_fpen <= r_pen;
                r_par  <= calc_parity(w_fifo_rdata, r_podd);
            end
            if (w_wr_ctrl) begin
                r_pen  <= i_bus.WBUS[CB_PEN];
                r_podd <= i_bus.WBUS[CB_PODD];
            end
        end
    end
`endif

    always_comb begin
        w_status           = '0;
        w_status[CB_READY] = ~w_full;
        w_status[CB_IDLE]  = (r_state == ST_IDLE) & w_empty;
        w_status[CB_OVR]   = r_ovr;
        w_status[CB_IE]    = r_ie;
`ifdef UART_TX_PARITY_EN
        w_status[CB_PEN]   = r_pen;
        w_status[CB_PODD]  = r_podd;
`endif
    end

    assign w_rd_en  = i_bus.RE & ((i_bus.ABUS == DADDR) | (i_bus.ABUS == CADDR));
    assign w_rd_val = (i_bus.ABUS == DADDR) ? DBITS'(w_count) : w_status;
    assign RBUS     = w_rd_en ? w_rd_val : {DBITS{1'bz}};

    assign TXD  = r_txd;
    assign INTR = r_intr;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_dev.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_dev
// Brief    : Self-checking bench: frame-level line model plus directed pins.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_dev;
    localparam int          DIVN = 4;
    localparam int          FD   = 4;
    localparam logic [15:0] DA   = 16'hFFD0;
    localparam logic [15:0] CA   = 16'hFFD4;

    logic        CLK  = 1'b0;
    logic        RSTN = 1'b0;
    wire  [15:0] RBUS;
    logic        INTR;
    logic        TXD;

    uart_tx_dev_if #(.ABITS(16), .DBITS(16)) bus_if ();

    for (genvar gi = 0; gi < 16; gi++) begin : g_pu
        pullup (RBUS[gi]);
    end

    uart_tx_dev #(
        .ABITS(16), .DBITS(16), .DADDR(DA), .CADDR(CA),
        .DIVN(DIVN), .DIVB(9), .FDEPTH(FD)
    ) dut (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .i_bus (bus_if),
        .RBUS  (RBUS),
        .INTR  (INTR),
        .TXD   (TXD)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting bytes and a queue of future line levels.
    logic [7:0] m_q[$];
    bit         m_line[$];
    bit         m_ie = 0, m_ovr = 0, m_pen = 0, m_podd = 0;
    bit         m_txd = 1, m_intr = 0;
    int         m_cnt0;
    logic [7:0] m_b;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_q.delete();
            m_line.delete();
            m_ie = 0; m_ovr = 0; m_pen = 0; m_podd = 0;
            m_txd = 1; m_intr = 0;
        end else begin
            m_cnt0 = m_q.size();
            m_intr = m_ie && (m_cnt0 < FD);
            m_txd  = (m_line.size() > 0) ? m_line.pop_front() : 1'b1;
            if (m_line.size() == 0 && m_cnt0 > 0) begin
                m_b = m_q.pop_front();
                for (int k = 0; k < DIVN; k++) m_line.push_back(1'b0);
                for (int i = 0; i < 8; i++)
                    for (int k = 0; k < DIVN; k++) m_line.push_back(m_b[i]);
                if (m_pen)
                    for (int k = 0; k < DIVN; k++) m_line.push_back((^m_b) ^ m_podd);
                for (int k = 0; k < DIVN; k++) m_line.push_back(1'b1);
            end
            if (bus_if.WE && bus_if.ABUS == DA) begin
                if (m_cnt0 < FD) m_q.push_back(bus_if.WBUS[7:0]);
                else m_ovr = 1;
            end
            if (bus_if.WE && bus_if.ABUS == CA) begin
                m_ie = bus_if.WBUS[8];
                if (!bus_if.WBUS[2]) m_ovr = 0;
`ifdef UART_TX_PARITY_EN
                m_pen  = bus_if.WBUS[4];
                m_podd = bus_if.WBUS[5];
`endif
            end
        end
    end

    function automatic logic [15:0] exp_rbus();
        logic [15:0] s;
        s = 16'hFFFF;
        if (bus_if.RE && bus_if.ABUS == CA) begin
            s    = 16'h0000;
            s[0] = (m_q.size() < FD);
            s[1] = (m_line.size() == 0) && (m_q.size() == 0);
            s[2] = m_ovr;
            s[8] = m_ie;
            s[4] = m_pen;
            s[5] = m_podd;
        end else if (bus_if.RE && bus_if.ABUS == DA) begin
            s = 16'(m_q.size());
        end
        return s;
    endfunction

    always @(negedge CLK) begin
        check("txd", {15'd0, TXD}, {15'd0, m_txd});
        check("intr", {15'd0, INTR}, {15'd0, m_intr});
        check("rbus", RBUS, exp_rbus());
    end

    // All stimulus tasks start and end 2 time units after a rising edge.
    task automatic tick();
        @(posedge CLK); #2;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus_if.WE = 1'b1; bus_if.ABUS = a; bus_if.WBUS = d;
        tick();
        bus_if.WE = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        bus_if.RE = 1'b1; bus_if.ABUS = a;
        #1 v = RBUS;
        tick();
        bus_if.RE = 1'b0;
    endtask

    bit          s[64];
    logic [15:0] v;
    logic [7:0]  a5;

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            s[i] = TXD;
        end
        tick();
    endtask

    initial begin
        bus_if.ABUS = '0; bus_if.WBUS = '0; bus_if.RE = 1'b0; bus_if.WE = 1'b0;
        repeat (3) tick();
        RSTN = 1'b1;
        tick();

        rd(CA, v); check("reset_status", v, 16'h0003);
        #1 check("rbus_z", RBUS, 16'hFFFF);
        check("reset_txd", {15'd0, TXD}, 16'd1);
        check("reset_intr", {15'd0, INTR}, 16'd0);

        wr(DA, 16'h00A5);
        capture(48);
        a5 = 8'hA5;
        check("pre_start0", {15'd0, s[0]}, 16'd1);
        check("pre_start1", {15'd0, s[1]}, 16'd1);
        check("start_first", {15'd0, s[2]}, 16'd0);
        check("start_last", {15'd0, s[5]}, 16'd0);
        for (int i = 0; i < 8; i++) check($sformatf("a5_bit%0d", i), {15'd0, s[7 + 4 * i]}, {15'd0, a5[i]});
        check("stop_first", {15'd0, s[38]}, 16'd1);
        check("stop_last", {15'd0, s[41]}, 16'd1);
        rd(CA, v); check("idle_after", v, 16'h0003);

        for (int i = 0; i < 5; i++) wr(DA, 16'(8'h11 * (i + 1)));
        wr(DA, 16'h00EE);
        rd(CA, v); check("ovr_status", v, 16'h0004);
        rd(DA, v); check("full_count", v, 16'h0004);
        repeat (5 * 40 + 10) tick();
        rd(CA, v); check("drained_ovr", v, 16'h0007);

        wr(CA, 16'h0100);
        @(negedge CLK); check("intr_lag", {15'd0, INTR}, 16'd0);
        @(negedge CLK); check("intr_on", {15'd0, INTR}, 16'd1);
        tick();
        for (int i = 0; i < 5; i++) wr(DA, 16'(i));
        tick();
        @(negedge CLK); check("intr_full", {15'd0, INTR}, 16'd0);
        repeat (45) tick();
        check("intr_popped", {15'd0, INTR}, 16'd1);
        wr(CA, 16'h0000);
        @(negedge CLK);
        @(negedge CLK); check("intr_off", {15'd0, INTR}, 16'd0);
        tick();
        rd(CA, v); check("ovr_cleared", v, 16'h0001);
        repeat (200) tick();

        wr(DA, 16'h003C);
        repeat (12) tick();
        RSTN = 1'b0;
        #1 check("rst_txd", {15'd0, TXD}, 16'd1);
        #1;
        rd(DA, v); check("rst_count", v, 16'h0000);
        RSTN = 1'b1;
        tick();
        wr(DA, 16'h005A);
        capture(44);
        check("clean_pre", {15'd0, s[1]}, 16'd1);
        check("clean_start", {15'd0, s[2]}, 16'd0);
        check("clean_bit0", {15'd0, s[7]}, 16'd0);
        check("clean_bit1", {15'd0, s[11]}, 16'd1);

`ifdef UART_TX_PARITY_EN
        wr(CA, 16'h0010);
        wr(DA, 16'h0007);
        capture(48);
        check("par_even", {15'd0, s[39]}, 16'd1);
        check("par_stop", {15'd0, s[43]}, 16'd1);
        rd(CA, v); check("par_status", v, 16'h0013);
        wr(CA, 16'h0030);
        wr(DA, 16'h0007);
        capture(48);
        check("par_odd", {15'd0, s[39]}, 16'd0);
        check("par_stop2", {15'd0, s[43]}, 16'd1);
        wr(CA, 16'h0000);
`endif

        for (int it = 0; it < 3000; it++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                RSTN = 1'b0;
                tick();
                RSTN = 1'b1;
                tick();
            end else if (r < 200) begin
                wr(DA, 16'($urandom));
            end else if (r < 260) begin
                wr(CA, 16'($urandom));
            end else if (r < 420) begin
                case ($urandom_range(0, 2))
                    0:       rd(DA, v);
                    1:       rd(CA, v);
                    default: rd(16'h1234, v);
                endcase
            end else begin
                tick();
            end
        end
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
